radio_seq_ctrl: RTL

- Per-radio power-up/down sequencer for BIT_WIDTH radio lanes.
- Drives PLL enable and RX enable in a fixed order: PLL on, wait for lock, guard time, RX on; on release, RX off, then PLL off.
- Consumes the synchronised PLL-settled flags from the timing-engine synchroniser.
- Round-robin arbitrates a single shared "startup slot" so that only one PLL is ever locking at a time, which bounds supply inrush.

---
 rtl/radio_seq_pkg.sv | 34 +++
 rtl/radio_seq_ctrl_rr_slot_arbiter.sv | 52 +++++
 rtl/radio_seq_ctrl.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/radio_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : radio_seq_pkg
// Description : Shared types and width helpers for the radio lane sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package radio_seq_pkg;

    localparam int c_state_w = 3;

    typedef enum logic [c_state_w-1:0] {
        ST_IDLE       = 3'd0,
        ST_WAIT_GRANT = 3'd1,
        ST_PLL_ON     = 3'd2,
        ST_GUARD      = 3'd3,
        ST_ACTIVE     = 3'd4,
        ST_SHUTDOWN   = 3'd5
    } lane_state_t;

    // Guard counter holds GUARD_CYCLES-1 down to 0.
    function automatic int calc_guard_w(input int guard_cycles);
        return (guard_cycles < 2) ? 1 : $clog2(guard_cycles);
    endfunction

    function automatic int calc_to_w(input int timeout_cycles);
        return (timeout_cycles < 1) ? 1 : $clog2(timeout_cycles + 1);
    endfunction

    function automatic int calc_ptr_w(input int n_lanes);
        return (n_lanes < 2) ? 1 : $clog2(n_lanes);
    endfunction

endpackage
`default_nettype wire

// File: rtl/radio_seq_ctrl_rr_slot_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_slot_arbiter
// Description : Round-robin single-slot arbiter; grants the first requester at
//               or after the pointer when the slot is free.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_slot_arbiter
    import radio_seq_pkg::*;
#(
    parameter int N_REQ = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] i_req,
    input  logic             i_slot_free,
    output logic [N_REQ-1:0] o_grant
);

    localparam int c_ptr_w = calc_ptr_w(N_REQ);

    logic [c_ptr_w-1:0]   r_ptr;
    logic [c_ptr_w-1:0]   w_ptr_nxt;
    logic [N_REQ-1:0]     w_req_rot;
    logic [N_REQ-1:0]     w_gnt_rot;
    logic [2*N_REQ-1:0]   w_gnt_dbl;

    // Rotate so the pointer lane sits at bit 0, pick the lowest set bit, rotate back.
    assign w_req_rot = N_REQ'({i_req, i_req} >> r_ptr);
    assign w_gnt_rot = i_slot_free ? (w_req_rot & (~w_req_rot + 1'b1)) : '0;
    assign w_gnt_dbl = {w_gnt_rot, w_gnt_rot} << r_ptr;
    assign o_grant   = N_REQ'(w_gnt_dbl >> N_REQ);

    always_comb begin
        w_ptr_nxt = r_ptr;
        for (int j = 0; j < N_REQ; j++) begin
            if (o_grant[j]) begin
                w_ptr_nxt = c_ptr_w'((j + 1) % N_REQ);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else begin
            r_ptr <= w_ptr_nxt;
        end
    end

endmodule
`default_nettype wire

// File: rtl/radio_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : radio_seq_ctrl
// Description : Per-lane PLL/RX power sequencer sharing one startup slot.
//               Optional PLL_ON timeout enabled by RADIO_SEQ_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module radio_seq_ctrl
    import radio_seq_pkg::*;
#(
    parameter int BIT_WIDTH      = 2,
    parameter int GUARD_CYCLES   = 4,
    parameter int TIMEOUT_CYCLES = 200
) (
    input  logic                 ck,
    input  logic                 arst,
    input  logic [BIT_WIDTH-1:0] rx_req,
    input  logic [BIT_WIDTH-1:0] pll_settled_sync,
    input  logic                 clear_err,
    output logic [BIT_WIDTH-1:0] pll_en,
    output logic [BIT_WIDTH-1:0] rx_en,
    output logic [BIT_WIDTH-1:0] ready,
    output logic                 slot_busy,
    output logic [BIT_WIDTH-1:0] err
);

    localparam int c_guard_w = calc_guard_w(GUARD_CYCLES);
`ifdef RADIO_SEQ_TIMEOUT_EN
    localparam int c_to_w = calc_to_w(TIMEOUT_CYCLES);
`else
    logic w_unused_timeout;
    assign w_unused_timeout = |TIMEOUT_CYCLES;
`endif

    logic [BIT_WIDTH-1:0] w_req;
    logic [BIT_WIDTH-1:0] w_grant;
    logic [BIT_WIDTH-1:0] w_hold;
    logic [BIT_WIDTH-1:0] w_hold_nxt;
    logic                 w_slot_free;

    // Slot is judged on pre-grant next state so a lane leaving PLL_ON/GUARD
    // hands the slot over on the same edge.
    assign w_slot_free = ~|w_hold_nxt;
    assign slot_busy   = |w_hold;
    assign ready       = rx_en;

    rr_slot_arbiter #(
        .N_REQ (BIT_WIDTH)
    ) u_arb (
        .clk         (ck),
        .rst         (arst),
        .i_req       (w_req),
        .i_slot_free (w_slot_free),
        .o_grant     (w_grant)
    );

    for (genvar i = 0; i < BIT_WIDTH; i++) begin : g_lane
        lane_state_t          r_state;
        lane_state_t          w_nxt_pre;
        lane_state_t          w_nxt;
        logic [c_guard_w-1:0] r_gcnt;
        logic [c_guard_w-1:0] w_gcnt_nxt;
        logic                 w_timeout;
        logic                 w_err_set;
        logic                 r_pll_en;
        logic                 r_rx_en;
        logic                 r_err;

`ifdef RADIO_SEQ_TIMEOUT_EN
        logic [c_to_w-1:0] r_tcnt;
        logic [c_to_w-1:0] w_tcnt_inc;

        assign w_tcnt_inc = r_tcnt + 1'b1;
        assign w_timeout  = (r_state == ST_PLL_ON) && (w_tcnt_inc == c_to_w'(TIMEOUT_CYCLES));

        always_ff @(posedge ck) begin
            if (arst) begin
                r_tcnt <= '0;
            end else if ((r_state == ST_PLL_ON) && (w_nxt == ST_PLL_ON)) begin
                r_tcnt <= w_tcnt_inc;
            end else begin
                r_tcnt <= '0;
            end
        end
`else
        assign w_timeout = 1'b0;
`endif

        always_comb begin
            w_nxt_pre  = r_state;
            w_gcnt_nxt = r_gcnt;
            w_err_set  = 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (rx_req[i]) w_nxt_pre = ST_WAIT_GRANT;
                end
                ST_WAIT_GRANT: begin
                    if (!rx_req[i]) w_nxt_pre = ST_IDLE;
                end
                ST_PLL_ON: begin
                    if (!rx_req[i]) begin
                        w_nxt_pre = ST_SHUTDOWN;
                    end else if (pll_settled_sync[i]) begin
                        w_nxt_pre  = ST_GUARD;
                        w_gcnt_nxt = c_guard_w'(GUARD_CYCLES - 1);
                    end else if (w_timeout) begin
                        w_nxt_pre = ST_SHUTDOWN;
                        w_err_set = 1'b1;
                    end
                end
                ST_GUARD: begin
                    if (!rx_req[i]) begin
                        w_nxt_pre = ST_SHUTDOWN;
                    end else if (!pll_settled_sync[i]) begin
                        w_nxt_pre = ST_PLL_ON;
                    end else if (r_gcnt == '0) begin
                        w_nxt_pre = ST_ACTIVE;
                    end else begin
                        w_gcnt_nxt = r_gcnt - 1'b1;
                    end
                end
                ST_ACTIVE: begin
                    if (!rx_req[i]) begin
                        w_nxt_pre = ST_SHUTDOWN;
                    end else if (!pll_settled_sync[i]) begin
                        w_nxt_pre = ST_SHUTDOWN;
                        w_err_set = 1'b1;
                    end
                end
                ST_SHUTDOWN: w_nxt_pre = ST_IDLE;
                default:     w_nxt_pre = ST_IDLE;
            endcase
        end

        assign w_nxt         = w_grant[i] ? ST_PLL_ON : w_nxt_pre;
        assign w_req[i]      = (r_state == ST_WAIT_GRANT) && rx_req[i];
        assign w_hold[i]     = (r_state == ST_PLL_ON) || (r_state == ST_GUARD);
        assign w_hold_nxt[i] = (w_nxt_pre == ST_PLL_ON) || (w_nxt_pre == ST_GUARD);

        always_ff @(posedge ck) begin
            if (arst) begin
                r_state  <= ST_IDLE;
                r_gcnt   <= '0;
                r_pll_en <= 1'b0;
                r_rx_en  <= 1'b0;
                r_err    <= 1'b0;
            end else begin
                r_state  <= w_nxt;
                r_gcnt   <= w_gcnt_nxt;
                r_pll_en <= (w_nxt == ST_PLL_ON) || (w_nxt == ST_GUARD) ||
                            (w_nxt == ST_ACTIVE) || (w_nxt == ST_SHUTDOWN);
                r_rx_en  <= (w_nxt == ST_ACTIVE);
                r_err    <= w_err_set | (r_err & ~clear_err);
            end
        end

        assign pll_en[i] = r_pll_en;
        assign rx_en[i]  = r_rx_en;
        assign err[i]    = r_err;
    end

endmodule
`default_nettype wire
